// File: rtl/l1_l2_arb_pkg.sv
// Shared types and default widths for the L1I/L1D -> L2 request arbiter.
package l1_l2_arb_pkg;

  localparam int unsigned TAG_W_DEF   = 21;
  localparam int unsigned INDEX_W_DEF = 5;
  localparam int unsigned LINE_W_DEF  = 512;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/l1_l2_arbiter_rr_arb2.sv
// Two-way round-robin picker between L1I and L1D; a tie goes to whoever did not win last.
module rr_arb2
  import l1_l2_arb_pkg::*;
(
  input  logic reqI,
  input  logic reqD,
  input  logic last_owner,
  output logic gnt_valid,
  output logic gnt_owner
);

  always_comb begin
    gnt_valid = reqI | reqD;
    gnt_owner = OWN_I;
    if (reqI && reqD) begin
      gnt_owner = (last_owner == OWN_I) ? OWN_D : OWN_I;
    end else if (reqD) begin
      gnt_owner = OWN_D;
    end
  end

endmodule

// File: rtl/l1_l2_arbiter.sv
// Shares the single L1->L2 request channel between L1I and L1D: latches the granted
// transaction, holds it until L2 ready, routes ready back to the owner, and watches for hangs.
module l1_l2_arbiter
  import l1_l2_arb_pkg::*;
#(
  parameter int unsigned TAG_W   = TAG_W_DEF,
  parameter int unsigned INDEX_W = INDEX_W_DEF,
  parameter int unsigned LINE_W  = LINE_W_DEF,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               read_L1I_L2,
  input  logic [TAG_W-1:0]   tag_L1I_L2,
  input  logic [INDEX_W-1:0] index_L1I_L2,
  input  logic               read_L1D_L2,
  input  logic [TAG_W-1:0]   tag_L1D_L2,
  input  logic [INDEX_W-1:0] index_L1D_L2,
  input  logic               write_L1D_L2,
  input  logic [TAG_W-1:0]   write_tag_L1D_L2,
  input  logic [INDEX_W-1:0] write_index_L1D_L2,
  input  logic [LINE_W-1:0]  write_data_L1_L2,
  input  logic               ready_L2_L1,
  output logic               read_L1_L2,
  output logic               write_L1_L2,
  output logic [TAG_W-1:0]   tag_L1_L2,
  output logic [INDEX_W-1:0] index_L1_L2,
  output logic [LINE_W-1:0]  write_data_L2,
  output logic               ready_L2_L1I,
  output logic               ready_L2_L1D,
  output logic               timeout_o
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t       state;
  owner_t           owner;
  owner_t           last_owner;
  logic [CNT_W-1:0] wd_count;
  logic             req_i;
  logic             req_d;
  logic             gnt_valid;
  logic             gnt_owner;

  assign req_i = read_L1I_L2;
  assign req_d = read_L1D_L2 | write_L1D_L2;

  rr_arb2 u_rr_arb2 (
    .reqI       (req_i),
    .reqD       (req_d),
    .last_owner (last_owner),
    .gnt_valid  (gnt_valid),
    .gnt_owner  (gnt_owner)
  );

  always_comb begin
    ready_L2_L1I = ready_L2_L1 && (state == BUSY) && (owner == OWN_I);
    ready_L2_L1D = ready_L2_L1 && (state == BUSY) && (owner == OWN_D);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      owner         <= OWN_I;
      last_owner    <= OWN_I;
      wd_count      <= '0;
      read_L1_L2    <= 1'b0;
      write_L1_L2   <= 1'b0;
      tag_L1_L2     <= '0;
      index_L1_L2   <= '0;
      write_data_L2 <= '0;
      timeout_o     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            owner      <= owner_t'(gnt_owner);
            last_owner <= owner_t'(gnt_owner);
            wd_count   <= '0;
            state      <= BUSY;
            // A pending write-back always goes before L1D's own fill.
            if ((gnt_owner == OWN_D) && write_L1D_L2) begin
              write_L1_L2   <= 1'b1;
              read_L1_L2    <= 1'b0;
              tag_L1_L2     <= write_tag_L1D_L2;
              index_L1_L2   <= write_index_L1D_L2;
              write_data_L2 <= write_data_L1_L2;
            end else begin
              write_L1_L2 <= 1'b0;
              read_L1_L2  <= 1'b1;
              tag_L1_L2   <= (gnt_owner == OWN_D) ? tag_L1D_L2 : tag_L1I_L2;
              index_L1_L2 <= (gnt_owner == OWN_D) ? index_L1D_L2 : index_L1I_L2;
            end
          end
        end
        BUSY: begin
          if (ready_L2_L1) begin
            read_L1_L2  <= 1'b0;
            write_L1_L2 <= 1'b0;
            state       <= RELEASE;
          end else if (TIMEOUT != 0) begin
            // Counter parks at its limit; the flag is sticky so nothing is lost.
            if (wd_count == CNT_LAST) begin
              timeout_o <= 1'b1;
            end else begin
              wd_count <= wd_count + CNT_W'(1);
            end
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Scoreboard bench for l1_l2_arbiter: a request-level model predicts each grant, a monitor
// compares every transaction the DUT presents to L2 and the ready routing back to L1.
module tb_l1_l2_arbiter;

  localparam int unsigned TW = 21;
  localparam int unsigned IW = 5;
  localparam int unsigned LW = 512;

  typedef struct {
    bit            wr;
    bit            own_d;
    logic [TW-1:0] tag;
    logic [IW-1:0] idx;
    logic [LW-1:0] data;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          rst_q = 1'b0;
  logic          read_L1I_L2, read_L1D_L2, write_L1D_L2, l2_ready;
  logic [TW-1:0] tag_L1I_L2, tag_L1D_L2, write_tag_L1D_L2, tag_L1_L2;
  logic [IW-1:0] index_L1I_L2, index_L1D_L2, write_index_L1D_L2, index_L1_L2;
  logic [LW-1:0] write_data_L1_L2, write_data_L2;
  logic          read_L1_L2, write_L1_L2, ready_L2_L1I, ready_L2_L1D, timeout_o;

  int   checks = 0;
  int   errors = 0;
  txn_t exp_q[$];
  txn_t cur;
  bit   active = 0;
  bit   after_ready = 0;

  // requester-side pending state
  bit            i_pend = 0, d_wr = 0, d_rd = 0;
  logic [TW-1:0] i_tag = '0, d_tag = '0, d_wtag = '0;
  logic [IW-1:0] i_idx = '0, d_idx = '0, d_widx = '0;
  logic [LW-1:0] d_wdata = '0;
  bit            model_last_d = 0;

  l1_l2_arbiter #(.TAG_W(TW), .INDEX_W(IW), .LINE_W(LW), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .read_L1I_L2(read_L1I_L2), .tag_L1I_L2(tag_L1I_L2), .index_L1I_L2(index_L1I_L2),
    .read_L1D_L2(read_L1D_L2), .tag_L1D_L2(tag_L1D_L2), .index_L1D_L2(index_L1D_L2),
    .write_L1D_L2(write_L1D_L2), .write_tag_L1D_L2(write_tag_L1D_L2),
    .write_index_L1D_L2(write_index_L1D_L2), .write_data_L1_L2(write_data_L1_L2),
    .ready_L2_L1(l2_ready),
    .read_L1_L2(read_L1_L2), .write_L1_L2(write_L1_L2), .tag_L1_L2(tag_L1_L2),
    .index_L1_L2(index_L1_L2), .write_data_L2(write_data_L2),
    .ready_L2_L1I(ready_L2_L1I), .ready_L2_L1D(ready_L2_L1D), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rst_q <= rst;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] d;
    for (int k = 0; k < LW / 32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_q) begin
      check("rst_read", read_L1_L2, '0);
      check("rst_write", write_L1_L2, '0);
      check("rst_tag", tag_L1_L2, '0);
      check("rst_index", index_L1_L2, '0);
      check("rst_data", write_data_L2, '0);
      check("rst_rdyI", ready_L2_L1I, '0);
      check("rst_rdyD", ready_L2_L1D, '0);
      check("rst_timeout", timeout_o, '0);
      active = 0;
      after_ready = 0;
    end else begin
      if (!active && !after_ready && (read_L1_L2 || write_L1_L2)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_txn: got read=%0b write=%0b tag=%0h expected none",
                   read_L1_L2, write_L1_L2, tag_L1_L2);
        end else begin
          cur = exp_q.pop_front();
          active = 1;
        end
      end
      if (active) begin
        check("txn_read", read_L1_L2, !cur.wr);
        check("txn_write", write_L1_L2, cur.wr);
        check("txn_tag", tag_L1_L2, cur.tag);
        check("txn_index", index_L1_L2, cur.idx);
        if (cur.wr) check("txn_data", write_data_L2, cur.data);
        check("busy_rdyI", ready_L2_L1I, l2_ready && !cur.own_d);
        check("busy_rdyD", ready_L2_L1D, l2_ready && cur.own_d);
        if (l2_ready) begin
          active = 0;
          after_ready = 1;
        end
      end else begin
        check("idle_rdyI", ready_L2_L1I, '0);
        check("idle_rdyD", ready_L2_L1D, '0);
        if (after_ready) begin
          check("rel_read", read_L1_L2, '0);
          check("rel_write", write_L1_L2, '0);
          after_ready = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_reqs();
    read_L1I_L2        = i_pend;
    tag_L1I_L2         = i_tag;
    index_L1I_L2       = i_idx;
    read_L1D_L2        = d_rd;
    tag_L1D_L2         = d_tag;
    index_L1D_L2       = d_idx;
    write_L1D_L2       = d_wr;
    write_tag_L1D_L2   = d_wtag;
    write_index_L1D_L2 = d_widx;
    write_data_L1_L2   = d_wdata;
  endtask

  task automatic gen_new();
    if (!i_pend && $urandom_range(0, 1) == 1) begin
      i_pend = 1;
      i_tag  = TW'($urandom);
      i_idx  = IW'($urandom);
    end
    if (!d_wr && !d_rd && $urandom_range(0, 1) == 1) begin
      case ($urandom_range(0, 2))
        0: d_rd = 1;
        1: d_wr = 1;
        default: begin d_rd = 1; d_wr = 1; end
      endcase
      d_tag   = TW'($urandom);
      d_idx   = IW'($urandom);
      d_wtag  = TW'($urandom);
      d_widx  = IW'($urandom);
      d_wdata = rand_line();
    end
  endtask

  // Predict the grant from the pending requests and queue the expected transaction.
  task automatic issue(output bit own_d, output bit wr);
    txn_t t;
    bit want_i, want_d;
    drive_reqs();
    want_i = i_pend;
    want_d = d_wr || d_rd;
    if (want_i && want_d) own_d = !model_last_d;
    else                  own_d = want_d;
    model_last_d = own_d;
    wr = own_d && d_wr;
    t.own_d = own_d;
    t.wr    = wr;
    t.tag   = !own_d ? i_tag : (wr ? d_wtag : d_tag);
    t.idx   = !own_d ? i_idx : (wr ? d_widx : d_idx);
    t.data  = d_wdata;
    exp_q.push_back(t);
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic wait_grant();
    int n = 0;
    while (!(read_L1_L2 || write_L1_L2) && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(read_L1_L2 || write_L1_L2)) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: got no L2 request after %0d cycles expected one", n);
      finish_run();
    end
  endtask

  // Owner changes its in-flight request fields; the L2 side must not follow.
  task automatic scramble(input bit own_d, input bit wr);
    if (own_d && wr) begin
      write_tag_L1D_L2   = TW'($urandom);
      write_index_L1D_L2 = IW'($urandom);
      write_data_L1_L2   = rand_line();
    end else if (own_d) begin
      tag_L1D_L2   = TW'($urandom);
      index_L1D_L2 = IW'($urandom);
    end else begin
      tag_L1I_L2   = TW'(1);
      index_L1I_L2 = IW'($urandom);
    end
  endtask

  task automatic complete(input int unsigned dly, input bit own_d, input bit wr);
    repeat (dly) begin
      scramble(own_d, wr);
      @(posedge clk); #1;
    end
    l2_ready = 1'b1;
    @(posedge clk); #1;
    l2_ready = ($urandom_range(0, 3) == 0);  // occasional spurious pulse in the dead cycle
    if (!own_d)  i_pend = 0;
    else if (wr) d_wr = 0;
    else         d_rd = 0;
    drive_reqs();
    @(posedge clk); #1;
    l2_ready = 1'b0;
  endtask

  task automatic do_round(input int unsigned dly, input bit add_rand);
    bit own_d, wr;
    if (add_rand) gen_new();
    if (!i_pend && !d_wr && !d_rd) begin
      i_pend = 1;
      i_tag  = TW'($urandom);
      i_idx  = IW'($urandom);
    end
    issue(own_d, wr);
    wait_grant();
    complete(dly, own_d, wr);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got simulation still running expected finish");
    $fatal(1);
  end

  initial begin
    bit own_d, wr;
    rst = 1'b1;
    l2_ready = 1'b0;
    drive_reqs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_last_d = 0;

    // tie right after reset goes to D
    i_pend = 1; i_tag = 21'h1A2B3; i_idx = 5'd5;
    d_rd = 1;   d_tag = 21'h0ABCD; d_idx = 5'd9;
    do_round(1, 0);
    // I alone, L2 ready in its fourth BUSY cycle
    do_round(3, 0);
    // second tie alternates back to D, ready in first BUSY cycle
    i_pend = 1; i_tag = TW'($urandom); i_idx = IW'($urandom);
    d_rd = 1;   d_tag = TW'($urandom); d_idx = IW'($urandom);
    do_round(0, 0);
    // D write+read vs waiting I: I first, then the write-back, then D's fill
    d_wr = 1; d_wtag = 21'h00FFF; d_widx = 5'd3; d_wdata = {16{32'hA5A5A5A5}};
    d_rd = 1; d_tag = 21'h12345;  d_idx = 5'd7;
    do_round(2, 0);
    do_round(1, 0);
    do_round(1, 0);

    repeat (150) do_round($urandom_range(0, 3), 1);

    i_pend = 0; d_wr = 0; d_rd = 0;
    drive_reqs();
    repeat (2) @(posedge clk);
    #1 check("timeout_quiet", timeout_o, '0);

    // watchdog: hold L2 ready off well past the limit
    i_pend = 1; i_tag = TW'($urandom); i_idx = IW'($urandom);
    issue(own_d, wr);
    wait_grant();
    repeat (14) begin @(posedge clk); #1; end
    check("wd_cycle15", timeout_o, '0);
    @(posedge clk); #1;
    check("wd_cycle16", timeout_o, '0);
    @(posedge clk); #1;
    check("wd_cycle17", timeout_o, 1'b1);
    repeat (5) begin @(posedge clk); #1; end
    check("wd_hold", timeout_o, 1'b1);
    complete(0, own_d, wr);
    repeat (2) begin @(posedge clk); #1; end
    check("wd_sticky", timeout_o, 1'b1);

    // reset in the middle of a D fill; D keeps requesting, stale ready in IDLE
    d_rd = 1; d_tag = TW'($urandom); d_idx = IW'($urandom);
    issue(own_d, wr);
    wait_grant();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_last_d = 0;
    l2_ready = 1'b1;
    issue(own_d, wr);
    @(posedge clk); #1;
    l2_ready = 1'b0;
    wait_grant();
    complete(1, own_d, wr);
    check("post_rst_timeout", timeout_o, '0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), '0);
    check("no_txn_open", active, '0);
    finish_run();
  end

endmodule

// File: doc/l1_l2_arbiter.md
# l1_l2_arbiter

- Sequential arbiter that shares the single L1↔L2 request channel between the instruction cache (L1I) and the data cache (L1D).
- Replaces the purely combinational request merge between the L1 caches and the L2 top.
- Latches one requester's transaction at grant and holds it stable to L2 until `ready_L2_L1`, then routes that ready back to the owner only.
- Provides round-robin fairness, write-before-read ordering for L1D, and a stuck-transaction watchdog.

## Interface

Parameters:
- `TAG_W`, 21: L1→L2 tag width
- `INDEX_W`, 5: L1→L2 index width
- `LINE_W`, 512: cache line width
- `TIMEOUT`, 1024: watchdog limit in cycles per grant; 0 disables

Ports (reset is synchronous, active-high):
- `clk` in 1: clock
- `rst` in 1: synchronous active-high reset
- `read_L1I_L2` in 1: L1I fill request
- `tag_L1I_L2` in `TAG_W`: L1I tag
- `index_L1I_L2` in `INDEX_W`: L1I index
- `read_L1D_L2` in 1: L1D fill request
- `tag_L1D_L2` in `TAG_W`: L1D fill tag
- `index_L1D_L2` in `INDEX_W`: L1D fill index
- `write_L1D_L2` in 1: L1D write-back request
- `write_tag_L1D_L2` in `TAG_W`: write-back tag
- `write_index_L1D_L2` in `INDEX_W`: write-back index
- `write_data_L1_L2` in `LINE_W`: write-back line
- `ready_L2_L1` in 1: L2 completion strobe
- `read_L1_L2` out 1: read to L2
- `write_L1_L2` out 1: write to L2
- `tag_L1_L2` out `TAG_W`: tag to L2
- `index_L1_L2` out `INDEX_W`: index to L2
- `write_data_L2` out `LINE_W`: latched write line to L2
- `ready_L2_L1I` out 1: completion to L1I
- `ready_L2_L1D` out 1: completion to L1D
- `timeout_o` out 1: sticky watchdog flag

## Operation

- FSM states: `IDLE`, `BUSY`, `RELEASE`.
- **IDLE**
  - Evaluate requests: `reqI = read_L1I_L2`; `reqD = read_L1D_L2 | write_L1D_L2`.
  - If only one requester is active, grant it.
  - If both are active, grant the requester that is not `last_owner`.
  - `last_owner` resets to I, so D wins the first tie after reset.
- **On grant (IDLE → BUSY)**
  - Register `owner`, `last_owner <= owner`, and the transaction fields.
  - D with `write_L1D_L2=1` (regardless of read): write transaction. Outputs are `write_L1_L2=1`, `read_L1_L2=0`, tag/index from `write_tag`/`write_index`, and `write_data_L2 <= write_data_L1_L2`.
  - Otherwise: read transaction. Outputs are `read_L1_L2=1` with the owner's tag/index.
- **BUSY**
  - Registered outputs hold constant; requester inputs are ignored.
  - `ready_L2_L1I = ready_L2_L1 & BUSY & owner==I`; `ready_L2_L1D` is the same with `owner==D`. Combinational, same cycle as L2 ready.
  - On `ready_L2_L1`: go to `RELEASE` and clear `read_L1_L2`/`write_L1_L2`.
- **RELEASE**
  - One dead cycle; no grant, ready outputs 0. Lets the owner drop its request.
  - Then go to `IDLE`.
- **L1D write then read**: L1D drops `write_L1D_L2` after its ready but keeps `read_L1D_L2`. Its fill then competes normally, so L1I wins if it is waiting.
- **Watchdog**
  - Counter clears on grant and increments each BUSY cycle.
  - At `count == TIMEOUT-1` without ready, `timeout_o` sets (sticky until `rst`). The transaction stays pending.
- **Spurious `ready_L2_L1`** in IDLE or RELEASE: ignored, not forwarded.
- **Reset**: when `rst=1` on a clock edge, regardless of state:
  - State goes to IDLE.
  - All outputs are 0, including tag, index, data and `timeout_o`.
  - Counter is 0 and `last_owner` is I.

## Timing

- Request sampled in IDLE at cycle N → L2 request outputs valid from N+1.
- `ready_L2_L1` at cycle M → owner's ready is high at M. L2 request outputs are 0 from M+1. State is IDLE at M+2, and a new grant is visible at M+3.
- Minimum turnaround between back-to-back grants: 3 cycles after ready.
- Requesters must deassert their request by M+2. A request still high in IDLE at M+2 is treated as a new transaction.
- `ready_L2_L1` is a single-cycle pulse. It is legal in the first BUSY cycle (N+1).

## Structure

- Package `l1_l2_arb_pkg` contains:
  - `arb_state_t` (`IDLE`/`BUSY`/`RELEASE`)
  - `owner_t` (`OWN_I`/`OWN_D`)
  - Default width constants 21/5/512
- Sub-module `rr_arb2`:
  - Combinational 2-way round-robin picker.
  - Inputs: `reqI`, `reqD`, `last_owner`. Outputs: `gnt_valid`, `gnt_owner`.
- The top holds the FSM, the transaction registers and the watchdog.

## Test plan

- **L1I solo read**: `read_L1I_L2=1`, tag 0x1A2B3, index 5 at N. Expect `read_L1_L2=1`, tag 0x1A2B3, index 5 at N+1. L2 ready at N+4 → `ready_L2_L1I=1` at N+4, `ready_L2_L1D=0`, and `read_L1_L2=0` at N+5.
- **Tie after reset**: both read requests in the same cycle. D is granted first. I is granted at ready+3. A second tie after that grants D (alternation).
- **L1D write+read**: both write and read asserted, write_tag 0x00FFF, write_index 3, data 0xA5…A5. Expect a write transaction with those values first, then a read with `tag_L1D_L2` after the dead cycle.
- **Input change mid-BUSY**: L1I tag changes to 0x00001 while granted. L2-side tag stays at the latched value until ready.
- **Watchdog**: `TIMEOUT=16`, L2 never ready. `timeout_o` rises at BUSY cycle 16 and stays high. Ready later completes normally, and `timeout_o` remains 1.
- **Reset mid-BUSY**: `rst` pulsed during BUSY. All outputs are 0 next cycle, a pending D request is re-granted once `rst` drops, and a stale ready is not forwarded.
